// File: rtl/circuit_seq_pkg.sv
// circuit_seq_pkg: shared state encoding and widths for the sweep sequencer
package circuit_seq_pkg;
  localparam int NUM_VEC = 16;
  localparam int VEC_W = 4;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/result_table.sv
// result_table: 16 x 2 result register file, sync write/clear, combinational read
module result_table
  import circuit_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [VEC_W-1:0] waddr,
  input  logic [1:0]       wdata,
  input  logic [VEC_W-1:0] raddr,
  output logic [1:0]       rdata
);
  logic [1:0] mem [NUM_VEC];
  always_ff @(posedge clk)
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/circuit_sweep_sequencer.sv
// circuit_sweep_sequencer: applies vectors to the logic block, settles, samples F1/F2 into a table
module circuit_sweep_sequencer
  import circuit_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [VEC_W-1:0] vec_in,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             F1,
  input  logic             F2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] f1_count,
  output logic [CNT_W-1:0] f2_count,
  input  logic [VEC_W-1:0] rd_addr,
  output logic [1:0]       rd_data
);
  state_t state, state_n;
  logic [7:0] settle_cnt;
  logic [VEC_W-1:0] idx, abcd;
  logic mode_q, settle_end, last;
  assign settle_end = settle_cnt == 8'(SETTLE_CYCLES - 1);
  assign last = mode_q || idx == 4'hf;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? APPLY : IDLE;
      APPLY:   state_n = settle_end ? SAMPLE : APPLY;
      SAMPLE:  state_n = last ? DONE : APPLY;
      default: state_n = IDLE;
    endcase
  end
  // abcd is loaded one edge ahead so the drive is registered and aligned with each state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      settle_cnt <= '0;
      idx <= '0;
      abcd <= '0;
      mode_q <= 1'b0;
      f1_count <= '0;
      f2_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          idx <= mode ? vec_in : '0;
          abcd <= mode ? vec_in : '0;
          settle_cnt <= '0;
          f1_count <= '0;
          f2_count <= '0;
        end
        APPLY: settle_cnt <= settle_end ? 8'd0 : settle_cnt + 8'd1;
        SAMPLE: begin
          f1_count <= f1_count + CNT_W'(F1);
          f2_count <= f2_count + CNT_W'(F2);
          idx <= last ? idx : idx + 4'd1;
          abcd <= last ? 4'd0 : idx + 4'd1;
        end
        default: abcd <= '0;
      endcase
    end
  end
  assign {A, B, C, D} = abcd;
  assign busy = state != IDLE;
  assign done = state == DONE;
  result_table u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (state == SAMPLE),
    .waddr(idx),
    .wdata({F1, F2}),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_circuit_sweep_sequencer.sv
// tb_circuit_sweep_sequencer: randomized scenarios against a table/count model of the sweep
module tb_circuit_sweep_sequencer;
  localparam int SETTLE = 4;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [3:0] vec_in = 0, rd_addr = 0;
  logic A, B, C, D, F1, F2, busy, done;
  logic [4:0] f1_count, f2_count;
  logic [1:0] rd_data;
  int cyc = 0, cyc0 = 0, rel, checks = 0, errors = 0;
  bit glitch = 0;
  logic [1:0] exp_tab [16];
  int exp_f1, exp_f2;

  circuit_sweep_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_in(vec_in),
    .A(A), .B(B), .C(C), .D(D), .F1(F1), .F2(F2),
    .busy(busy), .done(done), .f1_count(f1_count), .f2_count(f2_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub block: F1 = A&B, F2 = C|D; glitch mode toggles F1 except in the sample cycles
  always_comb begin
    rel = cyc - cyc0;
    F1 = glitch ? ((rel % (SETTLE + 1) == 0) ? 1'b0 : rel[0]) : (A & B);
    F2 = C | D;
  end

  task automatic check_table(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      checks++;
      if (rd_data !== exp_tab[a]) begin
        errors++;
        $display("FAIL %s table[%0d] got %b want %b", tag, a, rd_data, exp_tab[a]);
      end
    end
  endtask

  task automatic sweep(input bit m, input logic [3:0] v, input bit spam, input bit gl, input string tag);
    int n, total;
    logic [3:0] first, ev, vv;
    logic eb, ed;
    logic [1:0] e;
    n = m ? 1 : 16;
    first = m ? v : 4'd0;
    total = n * (SETTLE + 1) + 1;
    glitch = gl;
    @(posedge clk); #1;
    start = 1; mode = m; vec_in = v; cyc0 = cyc;
    for (int r = 1; r <= total + 1; r++) begin
      @(posedge clk); #1;
      start = (r <= total) && spam && (r == 20 || r == total || $urandom_range(3) == 0);
      mode = 1'($urandom); vec_in = 4'($urandom); rd_addr = 4'($urandom);
      @(negedge clk);
      eb = r <= total;
      ed = r == total;
      ev = r < total ? first + 4'((r - 1) / (SETTLE + 1)) : 4'd0;
      checks++;
      if ({A, B, C, D} !== ev || busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL %s cycle %0d abcd=%b busy=%b done=%b want abcd=%b busy=%b done=%b",
                 tag, r, {A, B, C, D}, busy, done, ev, eb, ed);
      end
    end
    start = 0; glitch = 0;
    exp_f1 = 0; exp_f2 = 0;
    for (int k = 0; k < n; k++) begin
      vv = first + 4'(k);
      e = {~gl & vv[3] & vv[2], vv[1] | vv[0]};
      exp_tab[vv] = e;
      exp_f1 += int'(e[1]);
      exp_f2 += int'(e[0]);
    end
    checks++;
    if (f1_count !== 5'(exp_f1) || f2_count !== 5'(exp_f2)) begin
      errors++;
      $display("FAIL %s counts got %0d/%0d want %0d/%0d", tag, f1_count, f2_count, exp_f1, exp_f2);
    end
    check_table(tag);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({A, B, C, D} !== 4'd0 || busy !== 0 || done !== 0 || f1_count !== 0 || f2_count !== 0) begin
      errors++;
      $display("FAIL reset abcd=%b busy=%b done=%b counts=%0d/%0d want all zero",
               {A, B, C, D}, busy, done, f1_count, f2_count);
    end
    for (int a = 0; a < 16; a++) exp_tab[a] = 2'b00;
    check_table("reset");
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_exhaustive();
    sweep(0, 4'd0, 0, 0, "exhaustive");
    checks++;
    if (f1_count !== 5'd4 || f2_count !== 5'd12) begin
      errors++;
      $display("FAIL exhaustive_counts got %0d/%0d want 4/12", f1_count, f2_count);
    end
    rd_addr = 4'b1100; #1;
    checks++;
    if (rd_data !== 2'b10) begin errors++; $display("FAIL rd_1100 got %b want 10", rd_data); end
    rd_addr = 4'b1111; #1;
    checks++;
    if (rd_data !== 2'b11) begin errors++; $display("FAIL rd_1111 got %b want 11", rd_data); end
  endtask

  task automatic test_single();
    sweep(1, 4'b0011, 0, 1, "single_glitch_0011");
    sweep(1, 4'b0011, 0, 0, "single_0011");
    rd_addr = 4'd3; #1;
    checks++;
    if (rd_data !== 2'b01 || f1_count !== 0 || f2_count !== 1) begin
      errors++;
      $display("FAIL single_0011 rd=%b counts=%0d/%0d want 01 0/1", rd_data, f1_count, f2_count);
    end
    for (int i = 0; i < 6; i++) sweep(1, 4'($urandom), 1'($urandom), 0, "single_random");
  endtask

  task automatic test_busy_start();
    sweep(0, 4'd0, 1, 0, "busy_start");
  endtask

  task automatic test_glitch();
    sweep(0, 4'd0, 0, 1, "glitch");
  endtask

  task automatic test_back_to_back();
    sweep(1, 4'($urandom), 0, 0, "b2b_single");
    sweep(0, 4'd0, 1, 0, "b2b_exhaustive");
  endtask

  task automatic test_mid_reset();
    bit saw_done = 0;
    @(posedge clk); #1;
    start = 1; mode = 0; cyc0 = cyc;
    for (int r = 1; r <= 30; r++) begin
      @(posedge clk); #1;
      start = 0;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({A, B, C, D} !== 4'd0 || busy !== 0 || done !== 0 || f1_count !== 0 || f2_count !== 0) begin
      errors++;
      $display("FAIL mid_reset abcd=%b busy=%b done=%b counts=%0d/%0d want all zero",
               {A, B, C, D}, busy, done, f1_count, f2_count);
    end
    for (int a = 0; a < 16; a++) exp_tab[a] = 2'b00;
    check_table("mid_reset");
    for (int r = 0; r < 100; r++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_reset_no_done got activity want idle"); end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_single();
    test_busy_start();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    sweep(1, 4'b1010, 0, 0, "after_reset_single");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
